isqrt_sched: RTL
================

# isqrt_sched

Shared integer square-root engine with a round-robin scheduler. It accepts radicands from up to N_REQ requesters, for example the edge-length and Heron-term units of the geofence pipeline. It grants one requester at a time and computes floor(sqrt(x)) with a fixed 11-step bit-serial search. It returns the result tagged with the requester id over a valid/ready handshake. It replaces the per-state binary-search loops with one time-multiplexed, fixed-latency datapath.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- W_IN, 22, radicand width
- W_OUT, 11, result width; must equal W_IN/2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- req_valid  in  N_REQ  per-requester request valid
- req_data  in  N_REQ*W_IN  packed radicands; requester i occupies bits [i*W_IN +: W_IN]
- req_ready  out  N_REQ  one-hot grant; combinational
- rsp_valid  out  1  result valid
- rsp_data  out  W_OUT  floor(sqrt(radicand))
- rsp_id  out  clog2(N_REQ)  index of the requester that owns the result
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in CALC and DONE

## Operation
- Three states:
  - IDLE: no operation in progress.
  - CALC: the search runs; holds bit index k, counting W_OUT-1 down to 0.
  - DONE: the result is held for the consumer.
- IDLE:
  - req_ready = one-hot of the round-robin winner among asserted req_valid bits. Search starts at ptr and wraps N_REQ-1 to 0.
  - If no req_valid is asserted, req_ready = 0.
  - On the accept edge (req_valid[i] & req_ready[i]): latch req_data slice i into rad, latch i into id, clear root, set k = W_OUT-1, go to CALC.
  - Also on the accept edge, ptr <= (i+1) mod N_REQ.
- CALC, each cycle:
  - trial = root | (1<<k).
  - If trial*trial <= rad (unsigned, 2*W_OUT-bit compare), root <= trial.
  - If k == 0, go to DONE; otherwise k <= k-1.
- DONE:
  - rsp_valid = 1; rsp_data = root; rsp_id = id.
  - All three hold stable until rsp_ready is sampled high, then go to IDLE.
  - req_ready = 0 in CALC and DONE.
- Requesters hold req_valid and req_data stable until granted. Deasserting req_valid before the grant withdraws the request with no side effect.
- The result is exact floor sqrt for every 0 <= x < 2^W_IN. The maximum input gives 2^W_OUT - 1 with no overflow.

## Timing
- Reset (reset = 0, asynchronous) sets:
  - state = IDLE, ptr = 0, root = 0, rad = 0, id = 0, k = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
- Reset mid-operation discards the operation; no rsp_valid is produced for it.
- Latency: the accept edge is edge 0; rsp_valid rises after edge W_OUT (11). Latency is independent of data.
- Throughput: at most one operation per W_OUT + 2 cycles when rsp_ready is held high. The sequence is accept, 11 CALC cycles, 1 DONE cycle, return to IDLE, next accept.
- A request that is valid while busy waits. It is arbitrated on the first IDLE cycle.
- rsp_ready = 1 in the same cycle rsp_valid first rises completes the handshake on that edge.
- rsp_ready held low stalls DONE indefinitely with outputs stable.
- Simultaneous requests: exactly one grant per accept. A requester valid continuously is granted within N_REQ operations.

## Structure
- Package isqrt_pkg holds:
  - Default widths W_IN and W_OUT.
  - State enum: IDLE, CALC, DONE.
  - A function that computes clog2 of N_REQ for the id width.
- Sub-module rr_arbiter (N_REQ): inputs req and ptr, output one-hot grant and binary grant index. It is purely combinational; ptr is owned by isqrt_sched.
- Squaring is one W_OUT x W_OUT multiplier shared across all CALC cycles.

## Test plan
- Single requester 0, x=1000000 -> rsp_valid 11 cycles after accept, rsp_data=1000, rsp_id=0.
- Boundary values, one at a time: x=0 -> 0; x=1 -> 1; x=999999 -> 999; x=4194303 -> 2047; x=4194304 is not representable, skip; x=3 -> 1.
- All 4 requesters valid from reset with x = 4, 9, 16, 25, held until granted, rsp_ready=1 -> responses in order id 0,1,2,3 with data 2,3,4,5. Then with requester 0 and 2 re-requesting: grant order 0, then 2.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_data and rsp_id stable; req_ready stays 0 for a pending requester until the handshake, then that requester is granted.
- Reset asserted in CALC (k=5), released 3 cycles later -> rsp_valid never pulses for the dropped op; ptr=0; next request from id 2 is granted immediately.
- Random 10k radicands from 3 requesters with random rsp_ready -> every result equals a floor-sqrt model. Per-requester response order matches issue order, and no id is starved for more than N_REQ operations.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared definitions for the isqrt_sched engine: default widths, FSM states
// and the id-width helper.
package isqrt_pkg;

   localparam int DEF_W_IN  = 22;
   localparam int DEF_W_OUT = 11;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr_i (wrapping) wins, reported both one-hot and as a binary index.
module rr_arbiter
   import isqrt_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]        req_i,
   input  logic [clog2(N_REQ)-1:0] ptr_i,
   output logic [N_REQ-1:0]        grant_o,
   output logic [clog2(N_REQ)-1:0] grant_idx_o
);

   localparam int ID_W = clog2(N_REQ);

   always_comb begin
      int              sum;
      logic            found;
      logic [ID_W-1:0] idx;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      sum         = 0;
      idx         = '0;
      for (int off = 0; off < N_REQ; off++) begin
         // Modulo by subtraction keeps non-power-of-two N_REQ in range.
         sum = int'(ptr_i) + off;
         if (sum >= N_REQ) begin
            sum = sum - N_REQ;
         end
         idx = ID_W'(sum);
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/isqrt_sched.sv
// Time-multiplexed floor-sqrt engine: round-robin grant, fixed W_OUT-step
// bit-serial search on one shared multiplier, tagged valid/ready result.
module isqrt_sched
   import isqrt_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W_IN  = DEF_W_IN,
   parameter int W_OUT = DEF_W_OUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*W_IN-1:0]   req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   output logic [W_OUT-1:0]        rsp_data,
   output logic [clog2(N_REQ)-1:0] rsp_id,
   input  logic                    rsp_ready,
   output logic                    busy
);

   localparam int ID_W = clog2(N_REQ);
   localparam int K_W  = clog2(W_OUT);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [W_IN-1:0]    rad_q, rad_d;
   logic [W_OUT-1:0]   root_q, root_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [N_REQ-1:0]   grant;
   logic [ID_W-1:0]    grantIdx;
   logic [W_OUT-1:0]   trial;
   logic [2*W_OUT-1:0] trialSq;
   logic               accept;

   rr_arbiter #(
      .N_REQ(N_REQ)
   ) u_arb (
      .req_i      (req_valid),
      .ptr_i      (ptr_q),
      .grant_o    (grant),
      .grant_idx_o(grantIdx)
   );

   // One multiplier squares the candidate root every CALC cycle.
   assign trial   = root_q | (W_OUT'(1) << k_q);
   assign trialSq = (2*W_OUT)'(trial) * (2*W_OUT)'(trial);

   assign accept    = (state_q == IDLE) && (|req_valid);
   assign req_ready = (state_q == IDLE) ? grant : '0;
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = root_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      rad_d   = rad_q;
      root_d  = root_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rad_d   = req_data[int'(grantIdx)*W_IN +: W_IN];
               id_d    = grantIdx;
               root_d  = '0;
               k_d     = K_W'(W_OUT - 1);
               ptr_d   = (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
               state_d = CALC;
            end
         end
         CALC: begin
            if (trialSq <= rad_q) begin
               root_d = trial;
            end
            if (k_q == '0) begin
               state_d = DONE;
            end else begin
               k_d = k_q - K_W'(1);
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         rad_q   <= '0;
         root_q  <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         rad_q   <= rad_d;
         root_q  <= root_d;
         k_q     <= k_d;
      end
   end

endmodule
